// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: internal program memory, datapath and fetch/decode/execute FSM.
// Optional build macro STEP_MODE_EN gates FETCH/DECODE/EXEC progress on i_step.
module acc_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_data,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_aeq0,
    output logic              o_apos,
    output logic [2:0]        o_ir,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_busy,
    output logic              o_halted
);
    // state   | meaning
    // IDLE    | after reset, waiting for start
    // FETCH   | latch opcode/address from M[pc], advance pc
    // DECODE  | route to EXEC, WAIT_IN or HALT
    // EXEC    | perform LOAD/STORE/ADD/SUB/JZ/JPOS
    // WAIT_IN | wait for in_valid, capture in_data into A
    // HALT    | stopped, A kept; start restarts from pc 0
    localparam int OPC_LSB = DATA_W - 3;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT_IN, S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];
    logic [DATA_W-1:0]   r_a;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_ir;
    logic [DATA_W-1:0]   w_word;
    logic [DATA_W-1:0]   w_operand;
    logic                w_adv;
    logic                w_aeq0;
    logic                w_apos;
    logic                w_prog_wr;
    logic                w_store_wr;

`ifdef STEP_MODE_EN
    assign w_adv = i_step;
`else
    // Free-running: i_step has no influence on progress.
    assign w_adv = i_step | 1'b1;
`endif

    assign w_word    = r_mem[r_pc];
    assign w_operand = r_mem[r_addr];
    assign w_aeq0    = (r_a == '0);
    assign w_apos    = !r_a[DATA_W-1] && !w_aeq0;

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_prog_wr  = 1'b0;
        w_store_wr = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_prog_wr = i_prog_we;
                if (i_start) w_next = S_FETCH;
            end
            S_FETCH:  if (w_adv) w_next = S_DECODE;
            S_DECODE: begin
                if (w_adv) begin
                    if (r_ir == OP_IN)        w_next = S_WAIT_IN;
                    else if (r_ir == OP_HALT) w_next = S_HALT;
                    else                      w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_adv) begin
                    w_next     = S_FETCH;
                    w_store_wr = (r_ir == OP_STORE);
                end
            end
            S_WAIT_IN: if (i_in_valid) w_next = S_FETCH;
            S_HALT: begin
                w_prog_wr = i_prog_we;
                if (i_start) w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_a    <= '0;
            r_pc   <= '0;
            r_addr <= '0;
            r_ir   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: if (i_start) r_pc <= '0;
                S_FETCH: begin
                    if (w_adv) begin
                        r_ir   <= w_word[OPC_LSB +: 3];
                        r_addr <= w_word[ADDR_W-1:0];
                        r_pc   <= r_pc + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_adv) begin
                        case (r_ir)
                            OP_LOAD: r_a <= w_operand;
                            OP_ADD:  r_a <= r_a + w_operand;
                            OP_SUB:  r_a <= r_a - w_operand;
                            OP_JZ:   if (w_aeq0) r_pc <= r_addr;
                            OP_JPOS: if (w_apos) r_pc <= r_addr;
                            default: ;
                        endcase
                    end
                end
                S_WAIT_IN: if (i_in_valid) r_a <= i_in_data;
                default: ;
            endcase
        end
    end

    // Memory has no reset; reset only blocks writes so an aborted STORE leaves it intact.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if (w_prog_wr)       r_mem[i_prog_addr] <= i_prog_data;
            else if (w_store_wr) r_mem[r_addr]      <= r_a;
        end
    end

    assign o_in_ready = (r_state == S_WAIT_IN);
    assign o_out_data = r_a;
    assign o_aeq0     = w_aeq0;
    assign o_apos     = w_apos;
    assign o_ir       = r_ir;
    assign o_pc       = r_pc;
    assign o_busy     = (r_state != S_IDLE) && (r_state != S_HALT);
    assign o_halted   = (r_state == S_HALT);
endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: vector table of single-instruction programs plus
// hand-written multi-cycle sequences (IN handshake, jump loop, reset abort, step mode).
module tb_acc_cpu_core;
    localparam int DW = 8;
    localparam int AW = 5;

    localparam logic [2:0] LOAD = 3'd0, STORE = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] IN = 3'd4, JZ = 3'd5, JPOS = 3'd6, HALT = 3'd7;

    logic          clk = 1'b0;
    logic          reset, start, step, prog_we, in_valid;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data, in_data;
    logic          in_ready, aeq0, apos, busy, halted;
    logic [DW-1:0] out_data;
    logic [2:0]    ir;
    logic [AW-1:0] pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clock(clk), .i_reset(reset), .i_start(start), .i_step(step),
        .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_data(prog_data),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .o_out_data(out_data), .o_aeq0(aeq0), .o_apos(apos), .o_ir(ir),
        .o_pc(pc), .o_busy(busy), .o_halted(halted)
    );

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] a;
        logic [DW-1:0] ma;
        logic [DW-1:0] mb;
        logic [DW-1:0] ea;
        logic          ez;
        logic          ep;
        logic [AW-1:0] epc;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] enc(input logic [2:0] op, input logic [AW-1:0] a);
        return {op, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Cycle count includes the edge that samples start.
    task automatic run(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!halted && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int k;
        logic [AW-1:0] exp_pc[8];

        reset = 1'b1; start = 1'b0; step = 1'b1; prog_we = 1'b0; in_valid = 1'b0;
        prog_addr = '0; prog_data = '0; in_data = '0;

        //              op    a   ma     mb     ea     z  p  pc
        tbl[0]  = '{LOAD, 21, 8'h10, 8'h5A, 8'h5A, 0, 1, 3};
        tbl[1]  = '{ADD,  21, 8'h05, 8'h07, 8'h0C, 0, 1, 3};
        tbl[2]  = '{SUB,  21, 8'h03, 8'h05, 8'hFE, 0, 0, 3};
        tbl[3]  = '{ADD,  21, 8'hFE, 8'h02, 8'h00, 1, 0, 3};
        tbl[4]  = '{ADD,  21, 8'h7F, 8'h01, 8'h80, 0, 0, 3};
        tbl[5]  = '{SUB,  21, 8'h09, 8'h04, 8'h05, 0, 1, 3};
        tbl[6]  = '{SUB,  21, 8'h80, 8'h80, 8'h00, 1, 0, 3};
        tbl[7]  = '{JZ,    4, 8'h00, 8'h00, 8'h00, 1, 0, 5};
        tbl[8]  = '{JZ,    4, 8'h03, 8'h00, 8'h03, 0, 1, 3};
        tbl[9]  = '{JPOS,  4, 8'h03, 8'h00, 8'h03, 0, 1, 5};
        tbl[10] = '{JPOS,  4, 8'h80, 8'h00, 8'h80, 0, 0, 3};

        tick();
        tick();
        reset = 1'b0;

        // memory written before reset survives it
        wr(5, 8'h33);
        wr(0, enc(LOAD, 5));
        wr(1, enc(HALT, 0));
        do_reset();
        check("rst out_data", 32'(out_data), 32'h0);
        check("rst pc", 32'(pc), 32'h0);
        check("rst aeq0", 32'(aeq0), 32'h1);
        check("rst apos", 32'(apos), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst halted", 32'(halted), 32'h0);
        check("rst in_ready", 32'(in_ready), 32'h0);
        check("rst ir", 32'(ir), 32'h0);
        run(cyc);
        check("mem kept over reset", 32'(out_data), 32'h33);

        // LOAD/ADD/STORE/HALT program
        do_reset();
        wr(10, 8'd5);
        wr(11, 8'd7);
        wr(0, enc(LOAD, 10));
        wr(1, enc(ADD, 11));
        wr(2, enc(STORE, 12));
        wr(3, enc(HALT, 0));
        run(cyc);
        check("prog cycles", 32'(cyc), 32'd12);
        check("prog halted", 32'(halted), 32'h1);
        check("prog A", 32'(out_data), 32'd12);
        wr(0, enc(LOAD, 12));
        wr(1, enc(ADD, 12));
        wr(2, enc(HALT, 0));
        run(cyc);
        check("stored M12 read back", 32'(out_data), 32'd24);

        // STORE overwrites the next instruction word before it is fetched
        do_reset();
        wr(10, 8'hE0);
        wr(0, enc(LOAD, 10));
        wr(1, enc(STORE, 2));
        wr(2, enc(ADD, 10));
        wr(3, enc(HALT, 0));
        run(cyc);
        check("self-modify cycles", 32'(cyc), 32'd9);
        check("self-modify A", 32'(out_data), 32'hE0);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            wr(20, tbl[i].ma);
            wr(21, tbl[i].mb);
            wr(0, enc(LOAD, 20));
            wr(1, enc(tbl[i].op, tbl[i].a));
            wr(2, enc(HALT, 0));
            wr(3, enc(HALT, 0));
            wr(4, enc(HALT, 0));
            run(cyc);
            check($sformatf("vec%0d halted", i), 32'(halted), 32'h1);
            check($sformatf("vec%0d A", i), 32'(out_data), 32'(tbl[i].ea));
            check($sformatf("vec%0d aeq0", i), 32'(aeq0), 32'(tbl[i].ez));
            check($sformatf("vec%0d apos", i), 32'(apos), 32'(tbl[i].ep));
            check($sformatf("vec%0d pc", i), 32'(pc), 32'(tbl[i].epc));
        end

        // IN handshake with in_valid held low
        do_reset();
        wr(0, enc(IN, 0));
        wr(1, enc(HALT, 0));
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        check("in_ready reached", 32'(in_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wait%0d in_ready", i), 32'(in_ready), 32'h1);
            check($sformatf("wait%0d busy", i), 32'(busy), 32'h1);
            tick();
        end
        in_data  = 8'h2A;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("in accepted in_ready", 32'(in_ready), 32'h0);
        check("in accepted A", 32'(out_data), 32'h2A);
        k = 0;
        while (!halted && k < 20) begin
            tick();
            k++;
        end
        check("in prog halted", 32'(halted), 32'h1);

        // JPOS falls through at A=0, JZ loops back to 0
        do_reset();
        wr(20, 8'h11);
        wr(0, enc(JPOS, 5));
        wr(1, enc(JZ, 0));
        exp_pc = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd0, 5'd1};
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            check($sformatf("loop pc%0d", i), 32'(pc), 32'(exp_pc[i]));
        end
        wr(20, 8'h55);
        check("loop still busy", 32'(busy), 32'h1);
        do_reset();
        wr(0, enc(LOAD, 20));
        wr(1, enc(HALT, 0));
        run(cyc);
        check("prog_we ignored while busy", 32'(out_data), 32'h11);

        // reset during EXEC of STORE aborts the write
        do_reset();
        wr(21, 8'h99);
        wr(22, 8'h44);
        wr(0, enc(LOAD, 21));
        wr(1, enc(STORE, 22));
        wr(2, enc(HALT, 0));
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("abort ir is STORE", 32'(ir), 32'(STORE));
        check("abort busy before", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'h0);
        check("abort halted", 32'(halted), 32'h0);
        check("abort A", 32'(out_data), 32'h0);
        wr(0, enc(LOAD, 22));
        wr(1, enc(HALT, 0));
        run(cyc);
        check("abort no write", 32'(out_data), 32'h44);

`ifdef STEP_MODE_EN
        // one FSM state per step pulse, pulses every 5th cycle
        do_reset();
        wr(10, 8'h09);
        wr(0, enc(LOAD, 10));
        wr(1, enc(HALT, 0));
        step  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step = (c % 5 == 0);
            tick();
            step = 1'b0;
            if (c == 4) check("step held in FETCH pc", 32'(pc), 32'h0);
            if (c == 10) check("step 2 pulses A", 32'(out_data), 32'h0);
            if (c == 10) check("step 2 pulses pc", 32'(pc), 32'h1);
            if (c == 15) check("step 3 pulses A", 32'(out_data), 32'h09);
        end
        step = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
Parametrised accumulator datapath with its own fetch/decode/execute controller. It replaces switch-driven control of the datapath (IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub) with an internal FSM. Program memory is internal and loaded through a write port. The board wrapper connects this core to the clock divider, switches and LEDs.

Parameters:
DATA_W, 8, accumulator/memory word width; must be >= ADDR_W+3
ADDR_W, 5, address width; memory depth is 2^ADDR_W words
OPC_LSB, DATA_W-3, bit position of the 3-bit opcode field in an instruction word (fixed derivation, not overridable)

Ports:
Clock  in  1  core clock (divided board clock)
Reset  in  1  synchronous, active-high reset
Start  in  1  begin execution from PC=0 (level sampled each cycle)
Step  in  1  single-step advance (used only with STEP_MODE_EN)
prog_we  in  1  program memory write enable
prog_addr  in  ADDR_W  program write address
prog_data  in  DATA_W  program write data
in_data  in  DATA_W  input operand for IN
in_valid  in  1  in_data is valid
in_ready  out  1  core is waiting in WAIT_IN
out_data  out  DATA_W  accumulator A
Aeq0  out  1  A == 0
Apos  out  1  A MSB == 0 and A != 0
IR  out  3  current opcode
pc  out  ADDR_W  program counter
busy  out  1  state is not IDLE or HALT
halted  out  1  state == HALT

Behaviour:
- Instruction word: [DATA_W-1:DATA_W-3] = opcode, [ADDR_W-1:0] = address a. Bits between are ignored.
- Opcodes:
  - 000 LOAD: A<=M[a]
  - 001 STORE: M[a]<=A
  - 010 ADD: A<=A+M[a]
  - 011 SUB: A<=A-M[a]
  - 100 IN: A<=in_data after handshake
  - 101 JZ: PC<=a if Aeq0
  - 110 JPOS: PC<=a if Apos
  - 111 HALT
- Memory: 2^ADDR_W x DATA_W register array with asynchronous read and synchronous write. Memory is not cleared by Reset.
- Reset: state=IDLE; A, PC and IR cleared to 0. Therefore out_data=0, Aeq0=1, Apos=0, in_ready=0, busy=0, halted=0. Reset mid-instruction aborts that instruction with no memory write. Reset has priority over all other inputs.
- FSM states: IDLE, FETCH, DECODE, EXEC, WAIT_IN, HALT.
  - IDLE: when Start=1, go to FETCH with PC=0.
  - FETCH: IR<=opcode of M[PC], latch address, PC<=PC+1 (wraps 2^ADDR_W-1 -> 0). Go to DECODE.
  - DECODE: opcode 100 -> WAIT_IN; 111 -> HALT; all others -> EXEC.
  - EXEC: perform the operation, then go to FETCH.
  - WAIT_IN: in_ready=1. When in_valid=1, A<=in_data and go to FETCH in the same cycle. While in_valid=0, hold indefinitely.
  - HALT: hold. Start=1 -> FETCH with PC=0; A is kept.
- Latency: 3 cycles per instruction; IN takes 2 cycles plus the wait.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W; no carry or overflow flags.
- Flags are combinational from A.
- Start while busy is ignored.
- prog_we is accepted only in IDLE or HALT and ignored otherwise.
- prog_we and Start in the same IDLE cycle: the write commits that cycle; FETCH in the next cycle sees the new word.
- STORE to the address of the next instruction: the next FETCH reads the updated word.
- A jump to the current address is legal and loops.

Optional Feature:
STEP_MODE_EN
- Defined: the FSM advances out of FETCH, DECODE and EXEC only in cycles where Step=1; otherwise it holds state with all registers unchanged. WAIT_IN still requires in_valid, with Step ignored. IDLE and HALT are unchanged.
- Undefined: Step is ignored and the core free-runs.

Test Plan:
- Reset -> out_data=0, pc=0, Aeq0=1, busy=0, halted=0; a memory word written before Reset is still readable by LOAD afterwards.
- Load program M0=LOAD 10, M1=ADD 11, M2=STORE 12, M3=HALT with M10=5 and M11=7, then Start -> halted after 11 cycles, out_data=12, M12=12 (checked by a follow-up LOAD).
- SUB wrap: A=3, M[a]=5, SUB -> out_data=0xFE, Apos=0, Aeq0=0. Then ADD of 2 -> A=0, Aeq0=1.
- IN with in_valid held low 4 cycles -> in_ready=1 for those cycles and busy=1. Then in_data=0x2A with in_valid=1 -> A=0x2A and in_ready=0 the next cycle.
- Loop: JZ back to 0 while A==0 and JPOS falls through -> pc sequence checked. prog_we during execution -> memory unchanged. Reset asserted during EXEC of STORE -> no write, state=IDLE.
- With STEP_MODE_EN: Step pulsed every 5th cycle -> one FSM state per pulse; the first instruction completes after 3 pulses.
